// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 arbiter feeding a single registered output beat with ready/valid backpressure.
// Define RR_MUX_ARBITER_BURST_EN to let the last winner keep the grant for up to MAX_BURST beats.
module rr_mux_arbiter #(
    parameter int NUM_PORTS_WIDTH = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_BURST       = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [(2**NUM_PORTS_WIDTH)-1:0]             req,
    input  logic [(2**NUM_PORTS_WIDTH)*DATA_WIDTH-1:0]  data_in,
    output logic [(2**NUM_PORTS_WIDTH)-1:0]             ack,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [DATA_WIDTH-1:0]                       out_data,
    output logic [NUM_PORTS_WIDTH-1:0]                  out_port
);

    localparam int N = 2 ** NUM_PORTS_WIDTH;

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("rr_mux_arbiter: MAX_BURST must be in 1..255");
    end

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [DATA_WIDTH-1:0]      out_data_q, out_data_d;
    logic [NUM_PORTS_WIDTH-1:0] out_port_q, out_port_d;
    logic [NUM_PORTS_WIDTH-1:0] last_grant_q, last_grant_d;

    logic                       free;
    logic                       rr_vld;
    logic [NUM_PORTS_WIDTH-1:0] rr_idx;
    logic [NUM_PORTS_WIDTH-1:0] win_idx;
    logic                       grant;

    assign free  = (state_q == IDLE) || out_ready;
    assign grant = !rst && free && rr_vld;

    // Walk the offsets from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        rr_vld = 1'b0;
        rr_idx = last_grant_q;
        for (int i = N; i >= 1; i--) begin
            if (req[last_grant_q + NUM_PORTS_WIDTH'(i)]) begin
                rr_vld = 1'b1;
                rr_idx = last_grant_q + NUM_PORTS_WIDTH'(i);
            end
        end
    end

`ifdef RR_MUX_ARBITER_BURST_EN
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       burst_keep;

    // A zero count means no burst is open yet, so reset priority still starts at port 0.
    assign burst_keep = req[last_grant_q] && (burst_cnt_q != 8'd0)
                        && (burst_cnt_q < 8'(MAX_BURST));
    assign win_idx    = burst_keep ? last_grant_q : rr_idx;

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (grant) begin
            burst_cnt_d = burst_keep ? burst_cnt_q + 8'd1 : 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_q <= 8'd0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign win_idx = rr_idx;
`endif

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            out_data_q   <= '0;
            out_port_q   <= '0;
            last_grant_q <= NUM_PORTS_WIDTH'(N - 1);
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_port_q   <= out_port_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (grant) begin
            state_d = HOLD;
        end else if (state_q == HOLD && out_ready) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        out_data_d   = out_data_q;
        out_port_d   = out_port_q;
        last_grant_d = last_grant_q;
        if (grant) begin
            out_data_d   = data_in[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            out_port_d   = win_idx;
            last_grant_d = win_idx;
        end
    end

    // Output logic
    always_comb begin
        ack       = '0;
        out_valid = (state_q == HOLD);
        if (grant) begin
            ack[win_idx] = 1'b1;
        end
    end

    assign out_data = out_data_q;
    assign out_port = out_port_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed literal checks plus randomized traffic against a
// behavioural arbitration model and an in-order beat scoreboard.
module tb_rr_mux_arbiter;

    localparam int NW   = 2;
    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int MAXB = 4;
`ifdef RR_MUX_ARBITER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] data_in;
    logic            out_ready = 1'b0;
    logic [N-1:0]    ack;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [NW-1:0]   out_port;

    logic [DW-1:0]   pdata [N];

    rr_mux_arbiter #(
        .NUM_PORTS_WIDTH(NW),
        .DATA_WIDTH     (DW),
        .MAX_BURST      (MAXB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data_in  (data_in),
        .ack      (ack),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    always_comb begin
        data_in = '0;
        for (int i = 0; i < N; i++) data_in[i*DW +: DW] = pdata[i];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model state: the beat the output register should hold, the last winner,
    // the open burst length, and every accepted beat in order.
    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } beat_t;

    bit            m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    int            m_port  = 0;
    int            m_last  = N - 1;
    int            m_cnt   = 0;
    logic [N-1:0]  m_ack_last = '0;
    int            waits [N];
    beat_t         sb [$];
    int            cw;
    beat_t         nb;
    beat_t         fb;

    function automatic int model_winner();
        int p;
        if (BURST && m_cnt >= 1 && m_cnt < MAXB && req[m_last]) return m_last;
        for (int k = 1; k <= N; k++) begin
            p = (m_last + k) % N;
            if (req[p]) return p;
        end
        return -1;
    endfunction

    initial for (int i = 0; i < N; i++) waits[i] = 0;

    always @(negedge clk) begin
        cw = -1;
        if (!rst && (!m_valid || out_ready)) cw = model_winner();
        chk("ack", 64'(ack), (cw >= 0) ? 64'(1) << cw : 64'd0);
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            chk("out_data", 64'(out_data), 64'(m_data));
            chk("out_port", 64'(out_port), 64'(m_port));
        end
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_port  = 0;
            m_last  = N - 1;
            m_cnt   = 0;
            sb.delete();
            for (int i = 0; i < N; i++) waits[i] = 0;
        end else begin
            if (m_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    fb = sb.pop_front();
                    chk("sb_data", 64'(out_data), 64'(fb.data));
                    chk("sb_port", 64'(out_port), 64'(fb.port));
                end
            end
            if (cw >= 0) begin
                nb.port = cw;
                nb.data = pdata[cw];
                sb.push_back(nb);
                m_valid = 1'b1;
                m_data  = pdata[cw];
                m_port  = cw;
                m_cnt   = (cw == m_last && m_cnt >= 1 && m_cnt < MAXB) ? m_cnt + 1 : 1;
                if (!BURST) begin
                    for (int p = 0; p < N; p++) begin
                        if (p == cw) begin
                            waits[p] = 0;
                        end else if (req[p]) begin
                            waits[p]++;
                            chk("starvation", 64'(waits[p] <= N - 1), 64'd1);
                        end else begin
                            waits[p] = 0;
                        end
                    end
                end
                m_last = cw;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
        m_ack_last = (cw >= 0) ? (N'(1) << cw) : '0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] seq28 [5];

    initial begin
        for (int i = 0; i < N; i++) pdata[i] = 32'h1000_0000 + i;
        rst = 1'b1;
        req = 4'b1111;
        out_ready = 1'b1;

        // reset state, ack suppressed while rst is high
        @(negedge clk);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_port", 64'(out_port), 64'd0);
        tick();
        rst = 1'b0;

`ifndef RR_MUX_ARBITER_BURST_EN
        seq28[0] = 4'b0001; seq28[1] = 4'b0010; seq28[2] = 4'b0100;
        seq28[3] = 4'b1000; seq28[4] = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rr_seq_ack", 64'(ack), 64'(seq28[i]));
            if (i > 0) chk("rr_seq_port", 64'(out_port), 64'(i - 1));
            tick();
        end
`else
        req = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("burst_ack", 64'(ack), ((i / 4) % 2 == 0) ? 64'd1 : 64'd2);
            tick();
        end
`endif

        // single requester under backpressure
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0100;
        pdata[2] = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall_first_ack", 64'(ack), 64'h4);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ack", 64'(ack), 64'd0);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", 64'(out_data), 64'hDEAD_BEEF);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_ack", 64'(ack), 64'h4);
        tick();

`ifndef RR_MUX_ARBITER_BURST_EN
        // wrap-around from last_grant = 3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1000;
        @(negedge clk);
        chk("wrap_setup_ack", 64'(ack), 64'h8);
        tick();
        req = 4'b1001;
        @(negedge clk);
        chk("wrap_ack0", 64'(ack), 64'h1);
        tick();
        @(negedge clk);
        chk("wrap_ack3", 64'(ack), 64'h8);
        chk("wrap_port", 64'(out_port), 64'd0);
        tick();
`endif

        // reset while a beat is in flight
        req = 4'b1111;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid_before", 64'(out_valid), 64'd1);
        chk("midrst_ack", 64'(ack), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid_after", 64'(out_valid), 64'd0);
        chk("midrst_first_ack", 64'(ack), 64'd1);
        tick();

        // randomized traffic; a requester holds its beat until acked
        req = '0;
        for (int c = 0; c < 10000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < N; p++) begin
                if (m_ack_last[p]) req[p] = 1'b0;
                if (!req[p] && $urandom_range(0, 2) == 0) begin
                    req[p]   = 1'b1;
                    pdata[p] = $urandom;
                end
            end
            tick();
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS_WIDTH, default 2, meaning log2 of the requester count (N = 2**NUM_PORTS_WIDTH).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the width of one beat per port.
REQ-003 SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive beats granted to one port (range 1..255).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port req, input, N bits: per-port request; each bit is held with its data until the matching ack.
REQ-007 SHALL have port data_in, input, N*DATA_WIDTH bits: flat data bus; port i occupies bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
REQ-008 SHALL have port ack, output, N bits: one-hot-or-zero combinational grant; ack[i]=1 means port i's beat is captured at this edge.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data/out_port hold a beat.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the beat when out_valid && out_ready.
REQ-011 SHALL have port out_data, output, DATA_WIDTH bits: registered selected beat.
REQ-012 SHALL have port out_port, output, NUM_PORTS_WIDTH bits: registered index of the port that supplied out_data.

Function
REQ-013 The output register SHALL be "free" in a cycle when out_valid==0 or (out_valid && out_ready).
REQ-014 When free and req!=0, exactly one ack bit SHALL assert for the winner; otherwise ack SHALL be 0.
REQ-015 On a cycle with ack[w]=1, the next edge SHALL load out_data=data_in slice w, out_port=w, out_valid=1 (one-cycle latency, registered select).
REQ-016 On a free cycle with req==0, out_valid SHALL go 0 at the next edge if it was drained; out_data/out_port SHALL hold.
REQ-017 When not free (out_valid && !out_ready), out_data, out_port and out_valid SHALL hold and ack SHALL be 0 (backpressure; no beat lost or duplicated).
REQ-018 Drain and refill in the same cycle SHALL be supported: full throughput of one beat per cycle with out_ready held high.
REQ-019 Arbitration SHALL be round-robin: search starts at port (last_grant+1) mod N, wrapping from N-1 to 0; first requesting port wins.
REQ-020 last_grant SHALL update only on a cycle with an ack; it SHALL not change on idle or stalled cycles.
REQ-021 A requester de-asserting req without ack SHALL simply be skipped; no state is kept for it.
REQ-022 Two-state FSM: IDLE (out_valid=0) and HOLD (out_valid=1); IDLE->HOLD on ack; HOLD->IDLE on drain with no ack; HOLD->HOLD otherwise.

Reset
REQ-023 While rst=1 at an edge: out_valid=0, out_data=0, out_port=0, last_grant=N-1 (port 0 highest priority first), burst count=0, FSM=IDLE.
REQ-024 While rst=1, ack SHALL be 0 regardless of req; a beat in flight at reset SHALL be discarded.

Configuration
REQ-025 Macro RR_MUX_ARBITER_BURST_EN SHALL select burst mode.
REQ-026 With RR_MUX_ARBITER_BURST_EN defined: if the port in last_grant is still requesting and it has received fewer than MAX_BURST consecutive acks, it SHALL win again; the count resets to 1 on any grant to a different port and after MAX_BURST the search proceeds per REQ-019.
REQ-027 Without RR_MUX_ARBITER_BURST_EN: every ack SHALL rotate per REQ-019; MAX_BURST SHALL be ignored and no burst counter SHALL exist.

Verification
REQ-028 Reset then req=4'b1111, out_ready=1, no burst -> ack sequence 0001,0010,0100,1000,0001; out_port 0,1,2,3 one cycle after each ack.
REQ-029 req=4'b0100 only, data port2=32'hDEADBEEF, out_ready=0 -> one ack, out_valid=1, out_data=32'hDEADBEEF held, ack=0 for 5 stalled cycles; out_ready=1 -> next ack same cycle.
REQ-030 req=4'b1001, last_grant=3 -> port 0 wins; next beat port 3 (wrap-around check).
REQ-031 BURST_EN, MAX_BURST=4, req=4'b0011 constant, out_ready=1 -> acks port0 x4, port1 x4, port0 x4.
REQ-032 rst asserted for one cycle while out_valid=1 and req=4'b1111 -> ack=0 in that cycle, out_valid=0 next, first subsequent grant is port 0.
REQ-033 Random req/out_ready for 10k cycles -> scoreboard: every acked beat appears once, in order, with correct out_port; no port starved more than N-1 grants (non-burst).
